// File: rtl/oki8243_pkg.sv
// Shared types and helpers for the 8243-style 4-bit expander bus responder.
`timescale 1ns/1ps
package oki8243_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_OR    = 2'd2,
        OP_AND   = 2'd3
    } bus_op_e;

    typedef logic [PORT_W-1:0]   port_idx_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef struct packed {
        bus_op_e   op;
        port_idx_t port;
    } bus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_WAIT_HI = 2'd3
    } exp_state_e;

    // New output-register value for a WRITE/OR/AND access.
    function automatic nibble_t apply_op(bus_op_e op, nibble_t cur, nibble_t d);
        case (op)
            OP_WRITE: return d;
            OP_OR:    return cur | d;
            OP_AND:   return cur & d;
            default:  return cur;
        endcase
    endfunction

endpackage

// File: rtl/oki8243_port_expander_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to a chosen level.
`timescale 1ns/1ps
module oki8243_port_expander_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/oki8243_port_expander.sv
// 8243-style expander responder: decodes PROG_n-framed commands on P2 and serves four
// 4-bit logical ports (READ, WRITE, OR, AND) with per-access strobes.
`timescale 1ns/1ps
module oki8243_port_expander
    import oki8243_pkg::*;
#(
    parameter int unsigned DRIVE_DLY = 4,
    parameter int unsigned MIN_LOW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_n,
    input  logic [3:0]  p2_i,
    output logic [3:0]  p2_o,
    output logic        p2_oe,
    output logic        p2_buf_oe,
    output logic [15:0] port_out,
    output logic [3:0]  port_dir,
    input  logic [15:0] port_in,
    output logic [3:0]  wr_stb,
    output logic [3:0]  rd_stb
);

    logic             prog_s;
    logic             prog_q;
    nibble_t          p2_d1, p2_d2, p2_q;
    logic [1:0]       warm_cnt;
    logic             armed;
    logic             fall, rise;
    exp_state_e       state, state_d;
    bus_cmd_t         cmd, cmd_d;
    logic [CNT_W-1:0] dly_cnt, dly_d;
    logic [CNT_W-1:0] low_cnt, low_d;
    nibble_t          p2_o_d;
    logic             p2_oe_d;
    logic [15:0]      out_d;
    logic [3:0]       dir_d, wr_d, rd_d;
    logic             complete;
    nibble_t          sel_in;

    oki8243_port_expander_sync_2ff #(.RESET_VAL(1'b1)) u_prog_sync (
        .clk (clk),
        .rst (rst),
        .d   (prog_n),
        .q   (prog_s)
    );

    // P2 delayed by the synchronizer depth, plus one extra stage aligned with prog_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_d1  <= '0;
            p2_d2  <= '0;
            p2_q   <= '0;
            prog_q <= 1'b1;
        end else begin
            p2_d1  <= p2_i;
            p2_d2  <= p2_d1;
            p2_q   <= p2_d2;
            prog_q <= prog_s;
        end
    end

    // The synchronizer resets high, so a real high level must be seen before a fall counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
            if (warm_cnt == 2'd3 && prog_s) armed <= 1'b1;
        end
    end

    assign fall   = armed & prog_q & ~prog_s;
    assign rise   = ~prog_q & prog_s;
    assign sel_in = port_in[{cmd.port, 2'b00} +: NIBBLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd      <= '{op: OP_READ, port: '0};
            dly_cnt  <= '0;
            low_cnt  <= '0;
            p2_o     <= '0;
            p2_oe    <= 1'b0;
            port_out <= '0;
            port_dir <= '0;
            wr_stb   <= '0;
            rd_stb   <= '0;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            dly_cnt  <= dly_d;
            low_cnt  <= low_d;
            p2_o     <= p2_o_d;
            p2_oe    <= p2_oe_d;
            port_out <= out_d;
            port_dir <= dir_d;
            wr_stb   <= wr_d;
            rd_stb   <= rd_d;
        end
    end

    assign p2_buf_oe = p2_oe;

    always_comb begin
        state_d  = state;
        cmd_d    = cmd;
        dly_d    = dly_cnt;
        low_d    = low_cnt;
        p2_o_d   = '0;
        p2_oe_d  = 1'b0;
        out_d    = port_out;
        dir_d    = port_dir;
        wr_d     = '0;
        rd_d     = '0;
        complete = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_CMD;
                    cmd_d.op   = bus_op_e'(p2_q[3:2]);
                    cmd_d.port = p2_q[1:0];
                    dly_d      = '0;
                    low_d      = CNT_W'(1);
                end
            end
            ST_CMD: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cmd.op != OP_READ) begin
                    state_d = ST_WAIT_HI;
                end else if (dly_cnt == CNT_W'(DRIVE_DLY - 1)) begin
                    state_d = ST_DRIVE;
                    p2_oe_d = 1'b1;
                    p2_o_d  = sel_in;
                end else begin
                    dly_d = dly_cnt + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    p2_oe_d = 1'b1;
                    p2_o_d  = sel_in;
                end
            end
            ST_WAIT_HI: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state != ST_IDLE && !prog_s && low_cnt != {CNT_W{1'b1}})
            low_d = low_cnt + CNT_W'(1);

        // Pulses shorter than MIN_LOW are treated as glitches and leave no trace.
        if (complete && low_cnt >= CNT_W'(MIN_LOW)) begin
            if (cmd.op == OP_READ) begin
                dir_d[cmd.port] = 1'b0;
                rd_d[cmd.port]  = 1'b1;
            end else begin
                out_d[{cmd.port, 2'b00} +: NIBBLE_W] =
                    apply_op(cmd.op, port_out[{cmd.port, 2'b00} +: NIBBLE_W], p2_q);
                dir_d[cmd.port] = 1'b1;
                wr_d[cmd.port]  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oki8243_port_expander.sv
// Bench for the expander: MCU-side readport/writeport tasks at 48 MHz with a strobe scoreboard.
`timescale 1ns/1ps
module tb_oki8243_port_expander;
    import oki8243_pkg::*;

    typedef struct {
        logic [7:0]  stb;   // {wr_stb, rd_stb}
        logic [15:0] out;
        logic [3:0]  dir;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_n = 1'b1;
    logic [3:0]  p2_i;
    logic [3:0]  p2_o;
    logic        p2_oe, p2_buf_oe;
    logic [15:0] port_out;
    logic [3:0]  port_dir;
    logic [15:0] port_in = '0;
    logic [3:0]  wr_stb, rd_stb;

    logic        mcu_en = 1'b0;
    logic [3:0]  mcu_val = '0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          contention = 0;
    int          n_fall13 = 0;
    int          n_rise13 = 0;
    logic        track13 = 1'b0;
    logic        prev13 = 1'b0;
    logic        oe_seen = 1'b0;
    realtime     t_fall, t_oe;

    logic [15:0] model_out = '0;
    logic [3:0]  model_dir = '0;
    sb_entry_t   sb[$];

    always #10.4 clk = ~clk;

    assign p2_i = p2_oe ? p2_o : (mcu_en ? mcu_val : 4'hF);

    oki8243_port_expander dut (
        .clk       (clk),
        .rst       (rst),
        .prog_n    (prog_n),
        .p2_i      (p2_i),
        .p2_o      (p2_o),
        .p2_oe     (p2_oe),
        .p2_buf_oe (p2_buf_oe),
        .port_out  (port_out),
        .port_dir  (port_dir),
        .port_in   (port_in),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [3:0] ref_op(bus_op_e op, logic [3:0] cur, logic [3:0] d);
        logic [3:0] r;
        r = cur;
        if (op == OP_WRITE) r = d;
        if (op == OP_OR)    r = cur | d;
        if (op == OP_AND)   r = cur & d;
        return r;
    endfunction

    always @(posedge p2_oe) begin
        t_oe    = $realtime;
        oe_seen = 1'b1;
    end

    // Strobe scoreboard plus bus-contention and port_out[13] toggle monitors.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst) begin
            if (p2_oe && mcu_en) contention++;
            if (p2_buf_oe !== p2_oe) check("buf_oe_eq", p2_buf_oe, p2_oe);
            if ((wr_stb | rd_stb) != 4'b0) begin
                if (sb.size() == 0) begin
                    check("stb_unexpected", {wr_stb, rd_stb}, 8'h00);
                end else begin
                    e = sb.pop_front();
                    check("stb", {wr_stb, rd_stb}, e.stb);
                    check("stb_port_out", port_out, e.out);
                    check("stb_port_dir", port_dir, e.dir);
                end
            end
            if (track13 && port_out[13] !== prev13) begin
                if (prev13) n_fall13++;
                else        n_rise13++;
            end
            prev13 = port_out[13];
        end
    end

    task automatic readport(input logic [1:0] p, output logic [3:0] v);
        sb_entry_t e;
        mcu_val = {2'b00, p};
        mcu_en  = 1'b1;
        #60;
        prog_n  = 1'b0;
        t_fall  = $realtime;
        t_oe    = -1.0;
        #40;
        mcu_en  = 1'b0;
        #660;
        v = p2_i;
        check("rd_oe", p2_oe, 1'b1);
        check("rd_oe_delay", (t_oe >= t_fall + 60.0) ? 1 : 0, 1);
        check("rd_data", v, port_in[{p, 2'b00} +: 4]);
        model_dir[p] = 1'b0;
        e.stb = {4'b0000, 4'b0001 << p};
        e.out = model_out;
        e.dir = model_dir;
        sb.push_back(e);
        prog_n = 1'b1;
        #200;
    endtask

    task automatic writeport(input logic [1:0] p, input bus_op_e op, input logic [3:0] d);
        sb_entry_t e;
        mcu_val = {op, p};
        mcu_en  = 1'b1;
        #60;
        prog_n  = 1'b0;
        #40;
        mcu_en  = 1'b0;
        #60;
        mcu_val = d;
        mcu_en  = 1'b1;
        model_out[{p, 2'b00} +: 4] = ref_op(op, model_out[{p, 2'b00} +: 4], d);
        model_dir[p] = 1'b1;
        e.stb = {4'b0001 << p, 4'b0000};
        e.out = model_out;
        e.dir = model_dir;
        sb.push_back(e);
        #600;
        prog_n = 1'b1;
        #60;
        mcu_en = 1'b0;
        #200;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        int         waited;

        // 1: reset values, then read port 2
        repeat (4) @(posedge clk);
        #1;
        check("rst_port_out", port_out, 16'h0);
        check("rst_port_dir", port_dir, 4'h0);
        check("rst_p2_oe", {p2_oe, p2_buf_oe}, 2'b00);
        check("rst_p2_o", p2_o, 4'h0);
        check("rst_stb", {wr_stb, rd_stb}, 8'h00);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        port_in[11:8] = 4'hA;
        readport(2'd2, v);
        check("t1_dir2", port_dir[2], 1'b0);

        // 2: WRITE / AND / OR on port 3
        writeport(2'd3, OP_WRITE, 4'b1111);
        check("t2_write", port_out[15:12], 4'b1111);
        writeport(2'd3, OP_AND, 4'b1101);
        check("t2_and", port_out[15:12], 4'b1101);
        check("t2_dir3", port_dir[3], 1'b1);
        writeport(2'd3, OP_OR, 4'b0010);
        check("t2_or", port_out[15:12], 4'b1111);
        port_in[7:4] = 4'h6;
        readport(2'd1, v);
        writeport(2'd0, OP_WRITE, 4'h9);

        // 4: 20 ns glitch carrying WRITE port 0 = 5
        oe_seen = 1'b0;
        mcu_val = {OP_WRITE, 2'd0};
        mcu_en  = 1'b1;
        #60;
        prog_n  = 1'b0;
        #20;
        prog_n  = 1'b1;
        mcu_val = 4'h5;
        #60;
        mcu_en  = 1'b0;
        #300;
        check("t4_port_out", port_out, model_out);
        check("t4_port_dir", port_dir, model_dir);
        check("t4_oe_seen", oe_seen, 1'b0);

        // 6: handshake loop on port 2 bit0, toggling port_out[13]
        track13 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            port_in[8] = 1'b1;
            readport(2'd2, v);
            check("t6_poll_hi", v[0], 1'b1);
            writeport(2'd3, OP_AND, 4'b1101);
            port_in[8] = 1'b0;
            readport(2'd2, v);
            check("t6_poll_lo", v[0], 1'b0);
            writeport(2'd3, OP_OR, 4'b0010);
        end
        track13 = 1'b0;
        check("t6_fall13", n_fall13, 8);
        check("t6_rise13", n_rise13, 8);
        check("t6_port3", port_out[15:12], 4'b1111);

        // 5: reset during a READ drive
        port_in[7:4] = 4'h3;
        mcu_val = {OP_READ, 2'd1};
        mcu_en  = 1'b1;
        #60;
        prog_n  = 1'b0;
        #40;
        mcu_en  = 1'b0;
        waited  = 0;
        while (!p2_oe && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("t5_reached_drive", p2_oe, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_p2_oe", {p2_oe, p2_buf_oe}, 2'b00);
        check("t5_p2_o", p2_o, 4'h0);
        check("t5_port_out", port_out, 16'h0);
        check("t5_port_dir", port_dir, 4'h0);
        check("t5_stb", {wr_stb, rd_stb}, 8'h00);
        model_out = '0;
        model_dir = '0;
        sb.delete();
        #40;
        prog_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // prog_n already low at reset release must not start an access
        #2;
        rst    = 1'b1;
        prog_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        prog_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t5_lowrel_out", port_out, 16'h0);
        check("t5_lowrel_dir", port_dir, 4'h0);

        writeport(2'd1, OP_WRITE, 4'hC);
        check("t5_after_wr", port_out[7:4], 4'hC);
        readport(2'd1, v);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("sb_drain", sb.size(), 0);
        check("contention", contention, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
